regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL expose: clock  in  1  sole clock; all state updates on its rising edge.
REQ-002 The block SHALL expose: reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-003 The block SHALL expose, for r in {alu, mac, ldr}: r_valid  in  1  write-back request pending.
REQ-004 The block SHALL expose, for each r: r_ready  out  1  request accepted this cycle (combinational grant).
REQ-005 The block SHALL expose, for each r: r_reg  in  4  destination register index; r_data  in  32  write-back value.
REQ-006 The block SHALL expose, for r in {alu, mac}: r_flag_we  in  1  update flags; r_nzcv  in  4  flag value (ldr has no flag inputs).
REQ-007 The block SHALL expose: rsv_valid  in  1  destination reservation at issue; rsv_reg  in  4  index reserved.
REQ-008 The block SHALL expose: regwrite  out  1, write_reg  out  4, write_data  out  32  register-file write port.
REQ-009 The block SHALL expose: flag_we  out  1, nzcv  out  4  CPSR flag write port.
REQ-010 The block SHALL expose: pc_load  out  1  write targets r15; busy  out  16  per-register pending-write mask; rsv_conflict  out  1  reservation of an already-busy register.

Function
REQ-011 Handshake: a transfer SHALL occur on a rising edge where r_valid and r_ready are both 1; at most one r_ready SHALL be 1 per cycle.
REQ-012 r_ready SHALL be 0 whenever r_valid is 0; when any valid is high, exactly one grant SHALL be issued (no idle cycle while requests are pending).
REQ-013 Requesters SHALL hold r_valid, r_reg, r_data, r_flag_we and r_nzcv stable until accepted; the block does not buffer unaccepted requests.
REQ-014 Latency: a request accepted at edge N SHALL drive regwrite=1, write_reg, and write_data during cycle N+1 only (one-cycle pulse, registered outputs).
REQ-015 flag_we SHALL pulse in the same cycle as regwrite when the accepted requester had r_flag_we=1; nzcv SHALL carry its r_nzcv, and ldr grants SHALL always give flag_we=0.
REQ-016 pc_load SHALL pulse with regwrite when the accepted r_reg equals 4'hF.
REQ-017 Back-to-back acceptances SHALL produce regwrite on consecutive cycles (throughput of one write per cycle).
REQ-018 Scoreboard: rsv_valid at edge N SHALL set busy[rsv_reg] from cycle N+1.
REQ-019 An acceptance at edge N SHALL clear busy[r_reg] from cycle N+1.
REQ-020 If a reservation and an acceptance target the same index on the same edge, the reservation SHALL win and the bit SHALL stay set.
REQ-021 rsv_valid on an index already busy SHALL pulse rsv_conflict for one cycle (cycle N+1), and the bit SHALL stay set.
REQ-022 An acceptance for a non-busy index SHALL still write normally and SHALL leave busy unchanged.
REQ-023 When no acceptance occurs at edge N, regwrite, flag_we and pc_load SHALL be 0 in cycle N+1; write_reg, write_data and nzcv SHALL hold their last values.

Reset
REQ-024 While reset is sampled high, all r_ready SHALL be 0 and no request SHALL be accepted.
REQ-025 reset SHALL clear regwrite, flag_we, pc_load and rsv_conflict, and SHALL set write_reg=0, write_data=0, nzcv=0 and busy=16'h0000.
REQ-026 reset SHALL set the arbitration pointer to alu, discarding any in-flight registered write without asserting regwrite.
REQ-027 Reset mid-operation SHALL take priority over any simultaneous acceptance or reservation on that edge.

Configuration
REQ-028 With macro REGFILE_WB_RR_EN defined, arbitration SHALL be round-robin: priority order starts at the requester after the last granted one (cyclic alu->mac->ldr), and the pointer SHALL advance only on an acceptance.
REQ-029 With REGFILE_WB_RR_EN undefined, arbitration SHALL be fixed priority alu > mac > ldr, and no pointer state SHALL exist.

Verification
REQ-030 Reset, then alu_valid with reg=3, data=32'hDEADBEEF, flag_we=1, nzcv=4'b1010 -> alu_ready=1 that cycle; next cycle regwrite=1, write_reg=3, write_data=32'hDEADBEEF, flag_we=1, nzcv=4'b1010.
REQ-031 All three valid for 6 cycles: with RR_EN -> grants alu, mac, ldr, alu, mac, ldr; without RR_EN -> grants alu only; regwrite is high every cycle after the first.
REQ-032 rsv_valid with reg=5, then alu write to reg 5 two cycles later -> busy[5]=1 until the cycle after acceptance, then 0; a second rsv on reg 5 while busy -> rsv_conflict=1 for one cycle.
REQ-033 ldr write to reg 15 with data=32'h0000_0100 -> pc_load=1 and regwrite=1 in the same cycle, flag_we=0.
REQ-034 Same-edge rsv_reg=7 and acceptance of reg 7 -> busy[7] stays 1; reset asserted during a pending mac request -> mac_ready=0, busy=0, and no regwrite in the following cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for alu/mac/ldr into a single register-file write port, with a pending-write scoreboard.
// Define REGFILE_WB_RR_EN for round-robin arbitration; otherwise fixed priority alu > mac > ldr.
module regfile_wb_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_reg,
  input  logic [31:0] alu_data,
  input  logic        alu_flag_we,
  input  logic [3:0]  alu_nzcv,
  input  logic        mac_valid,
  output logic        mac_ready,
  input  logic [3:0]  mac_reg,
  input  logic [31:0] mac_data,
  input  logic        mac_flag_we,
  input  logic [3:0]  mac_nzcv,
  input  logic        ldr_valid,
  output logic        ldr_ready,
  input  logic [3:0]  ldr_reg,
  input  logic [31:0] ldr_data,
  input  logic        rsv_valid,
  input  logic [3:0]  rsv_reg,
  output logic        regwrite,
  output logic [3:0]  write_reg,
  output logic [31:0] write_data,
  output logic        flag_we,
  output logic [3:0]  nzcv,
  output logic        pc_load,
  output logic [15:0] busy,
  output logic        rsv_conflict
);

  logic [2:0]  valid_w;
  logic [2:0]  grant;
  logic        accept;
  logic [3:0]  reg_sel;
  logic [31:0] data_sel;
  logic        fwe_sel;
  logic [3:0]  nzcv_sel;
  logic [15:0] busy_d;

  logic        regwrite_q;
  logic [3:0]  write_reg_q;
  logic [31:0] write_data_q;
  logic        flag_we_q;
  logic [3:0]  nzcv_q;
  logic        pc_load_q;
  logic [15:0] busy_q;
  logic        rsv_conflict_q;

  assign valid_w = {ldr_valid, mac_valid, alu_valid};

`ifdef REGFILE_WB_RR_EN
  // ptr_q names the requester that gets first look this cycle (0=alu, 1=mac, 2=ldr)
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  always_comb begin
    grant = 3'b000;
    if (!reset) begin
      unique case (ptr_q)
        2'd1: begin
          if (valid_w[1])      grant = 3'b010;
          else if (valid_w[2]) grant = 3'b100;
          else if (valid_w[0]) grant = 3'b001;
        end
        2'd2: begin
          if (valid_w[2])      grant = 3'b100;
          else if (valid_w[0]) grant = 3'b001;
          else if (valid_w[1]) grant = 3'b010;
        end
        default: begin
          if (valid_w[0])      grant = 3'b001;
          else if (valid_w[1]) grant = 3'b010;
          else if (valid_w[2]) grant = 3'b100;
        end
      endcase
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = 2'd1;
    else if (grant[1]) ptr_d = 2'd2;
    else if (grant[2]) ptr_d = 2'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant = 3'b000;
    if (!reset) begin
      if (valid_w[0])      grant = 3'b001;
      else if (valid_w[1]) grant = 3'b010;
      else if (valid_w[2]) grant = 3'b100;
    end
  end
`endif

  assign accept    = |grant;
  assign alu_ready = grant[0];
  assign mac_ready = grant[1];
  assign ldr_ready = grant[2];

  always_comb begin
    reg_sel  = alu_reg;
    data_sel = alu_data;
    fwe_sel  = alu_flag_we;
    nzcv_sel = alu_nzcv;
    if (grant[1]) begin
      reg_sel  = mac_reg;
      data_sel = mac_data;
      fwe_sel  = mac_flag_we;
      nzcv_sel = mac_nzcv;
    end else if (grant[2]) begin
      reg_sel  = ldr_reg;
      data_sel = ldr_data;
      fwe_sel  = 1'b0;
      nzcv_sel = nzcv_q;
    end
  end

  // Clear on write-back first so a same-edge reservation of that index keeps it set.
  always_comb begin
    busy_d = busy_q;
    if (accept)    busy_d[reg_sel] = 1'b0;
    if (rsv_valid) busy_d[rsv_reg] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regwrite_q     <= 1'b0;
      write_reg_q    <= 4'h0;
      write_data_q   <= 32'h0;
      flag_we_q      <= 1'b0;
      nzcv_q         <= 4'h0;
      pc_load_q      <= 1'b0;
      busy_q         <= 16'h0000;
      rsv_conflict_q <= 1'b0;
    end else begin
      regwrite_q     <= accept;
      flag_we_q      <= accept & fwe_sel;
      pc_load_q      <= accept && (reg_sel == 4'hF);
      rsv_conflict_q <= rsv_valid & busy_q[rsv_reg];
      busy_q         <= busy_d;
      if (accept) begin
        write_reg_q  <= reg_sel;
        write_data_q <= data_sel;
      end
      // nzcv only moves on an actual flag write; otherwise it holds the last flags
      if (accept && fwe_sel) nzcv_q <= nzcv_sel;
    end
  end

  assign regwrite     = regwrite_q;
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign flag_we      = flag_we_q;
  assign nzcv         = nzcv_q;
  assign pc_load      = pc_load_q;
  assign busy         = busy_q;
  assign rsv_conflict = rsv_conflict_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a cycle-level behavioural model of grants, writes and the scoreboard.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid [3];
  logic        req_ready [3];
  logic [3:0]  req_reg   [3];
  logic [31:0] req_data  [3];
  logic        req_fwe   [3];
  logic [3:0]  req_nzcv  [3];
  logic        rsv_valid;
  logic [3:0]  rsv_reg;
  logic        regwrite, flag_we, pc_load, rsv_conflict;
  logic [3:0]  write_reg, nzcv;
  logic [31:0] write_data;
  logic [15:0] busy;

  always #5 clock = ~clock;

  regfile_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .alu_valid(req_valid[0]), .alu_ready(req_ready[0]), .alu_reg(req_reg[0]),
    .alu_data(req_data[0]), .alu_flag_we(req_fwe[0]), .alu_nzcv(req_nzcv[0]),
    .mac_valid(req_valid[1]), .mac_ready(req_ready[1]), .mac_reg(req_reg[1]),
    .mac_data(req_data[1]), .mac_flag_we(req_fwe[1]), .mac_nzcv(req_nzcv[1]),
    .ldr_valid(req_valid[2]), .ldr_ready(req_ready[2]), .ldr_reg(req_reg[2]),
    .ldr_data(req_data[2]),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .flag_we(flag_we), .nzcv(nzcv), .pc_load(pc_load), .busy(busy),
    .rsv_conflict(rsv_conflict)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_g = -1;

  // Behavioural model state
  int          first_m = 0;       // requester looked at first (RR only)
  logic [15:0] busy_m = '0;
  logic        e_rw, e_fw, e_pc, e_cf;
  logic [3:0]  e_wr = '0, e_nz = '0;
  logic [31:0] e_wd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_grant();
    int idx;
    if (reset) return -1;
    for (int k = 0; k < 3; k++) begin
`ifdef REGFILE_WB_RR_EN
      idx = (first_m + k) % 3;
`else
      idx = k;
`endif
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock: check grants mid-cycle, advance the model, check registered outputs after the edge.
  task automatic step();
    int g;
    @(negedge clock);
    g = exp_grant();
    check("alu_ready", req_ready[0], g == 0);
    check("mac_ready", req_ready[1], g == 1);
    check("ldr_ready", req_ready[2], g == 2);
    if (reset) begin
      busy_m = '0; first_m = 0;
      e_rw = 0; e_fw = 0; e_pc = 0; e_cf = 0;
      e_wr = '0; e_wd = '0; e_nz = '0;
    end else begin
      e_cf = rsv_valid && busy_m[rsv_reg];
      e_rw = (g >= 0);
      e_fw = 0; e_pc = 0;
      if (g >= 0) begin
        e_wr = req_reg[g];
        e_wd = req_data[g];
        e_pc = (req_reg[g] == 4'd15);
        e_fw = (g != 2) && req_fwe[g];
        if (e_fw) e_nz = req_nzcv[g];
        busy_m[req_reg[g]] = 1'b0;
        first_m = (g + 1) % 3;
        $display("tx cycle=%0d req=%0d reg=%0d data=%h", cyc, g, req_reg[g], req_data[g]);
      end
      if (rsv_valid) busy_m[rsv_reg] = 1'b1;
    end
    last_g = g;
    @(posedge clock);
    #1;
    cyc++;
    check("regwrite", regwrite, e_rw);
    check("write_reg", write_reg, e_wr);
    check("write_data", write_data, e_wd);
    check("flag_we", flag_we, e_fw);
    check("nzcv", nzcv, e_nz);
    check("pc_load", pc_load, e_pc);
    check("busy", busy, busy_m);
    check("rsv_conflict", rsv_conflict, e_cf);
  endtask

  task automatic idle_inputs();
    for (int r = 0; r < 3; r++) begin
      req_valid[r] = 0; req_reg[r] = '0; req_data[r] = '0;
      req_fwe[r] = 0; req_nzcv[r] = '0;
    end
    rsv_valid = 0; rsv_reg = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  int exp_seq [6];

  initial begin
    idle_inputs();
    reset = 1;
    // Requests present during reset must not be granted
    req_valid[0] = 1; req_valid[1] = 1; req_valid[2] = 1;
    step();
    step();
    reset = 0;
    idle_inputs();
    check("reset_busy", busy, 16'h0000);

    // Basic alu write with flags
    req_valid[0] = 1; req_reg[0] = 4'd3; req_data[0] = 32'hDEADBEEF;
    req_fwe[0] = 1; req_nzcv[0] = 4'b1010;
    step();
    idle_inputs();
    check("basic_wd", write_data, 32'hDEADBEEF);
    check("basic_nz", nzcv, 4'b1010);
    step();

    // All three contending for 6 cycles, starting from a fresh pointer
    do_reset();
    for (int r = 0; r < 3; r++) begin
      req_valid[r] = 1; req_reg[r] = 4'(r + 1); req_data[r] = 32'h1000 + r;
      req_fwe[r] = 1; req_nzcv[r] = 4'(r + 4);
    end
`ifdef REGFILE_WB_RR_EN
    exp_seq = '{0, 1, 2, 0, 1, 2};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 6; i++) begin
      step();
      check("seq_grant", last_g, exp_seq[i]);
    end
    idle_inputs();
    step();

    // Reservation, conflicting reservation, then release by write-back
    do_reset();
    rsv_valid = 1; rsv_reg = 4'd5;
    step();
    check("rsv5_set", busy[5], 1'b1);
    step();
    check("rsv5_conflict", rsv_conflict, 1'b1);
    rsv_valid = 0;
    req_valid[0] = 1; req_reg[0] = 4'd5; req_data[0] = 32'h55;
    step();
    check("rsv5_clear", busy[5], 1'b0);
    check("rsv5_conflict_drop", rsv_conflict, 1'b0);
    idle_inputs();

    // ldr write to the PC
    req_valid[2] = 1; req_reg[2] = 4'hF; req_data[2] = 32'h0000_0100;
    step();
    check("pc_load_pulse", pc_load, 1'b1);
    idle_inputs();

    // Same-edge reservation and write-back of reg 7: reservation wins
    rsv_valid = 1; rsv_reg = 4'd7;
    req_valid[0] = 1; req_reg[0] = 4'd7; req_data[0] = 32'h77;
    step();
    check("same_edge_busy7", busy[7], 1'b1);
    idle_inputs();

    // Reset while mac is pending
    req_valid[1] = 1; req_reg[1] = 4'd9; req_data[1] = 32'h99;
    reset = 1;
    step();
    check("rst_mac_busy", busy, 16'h0000);
    idle_inputs();
    reset = 0;
    step();

    // Randomized traffic; requests stay stable until accepted
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 3; r++) begin
        if (!req_valid[r] || last_g == r) begin
          req_valid[r] = ($urandom_range(2) != 0);
          req_reg[r]   = 4'($urandom_range(15));
          req_data[r]  = $urandom;
          req_fwe[r]   = 1'($urandom_range(1));
          req_nzcv[r]  = 4'($urandom_range(15));
        end
      end
      rsv_valid = ($urandom_range(3) == 0);
      rsv_reg   = 4'($urandom_range(15));
      reset     = ($urandom_range(63) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
